// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the PC, issues word-aligned requests to instruction memory and loads
// the IF/ID register. A one-entry buffer keeps an instruction that memory
// returned while the hazard unit was stalling, so the fetch is not repeated.
//
// Optional feature: define FETCH_STALL_CNT_EN to add the FetchStallCnt output,
// a saturating count of cycles in which the stage is active but the PC does
// not advance.
//
// Memory handshake: IMemReq/IMemAddr form the request. A transfer takes place
// in any cycle where IMemReq=1 and IMemAck=1, and IMemData is valid only in
// that cycle. While IMemReq=1 and IMemAck=0 the same address is presented again
// on the next cycle. IMemAck is ignored whenever IMemReq=0.

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        FlushSignal,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_Instr,
    output logic        IFID_Valid,
    output logic        FetchBusy,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0] FetchStallCnt,
`endif
    output logic [1:0]  dbg_state
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Registered state
    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] buf_data;
    logic        buf_vld;
    logic        req_q;

    // Next-state values
    logic [1:0]  state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] buf_data_nxt;
    logic        buf_vld_nxt;
    logic [31:0] ifid_pc4_nxt;
    logic [31:0] ifid_instr_nxt;
    logic        ifid_valid_nxt;

    // Per-cycle decisions
    logic        advance;      // PC moves to PC+4 this cycle
    logic        load_req;     // an instruction is ready to enter IF/ID
    logic [31:0] load_instr;   // the instruction that would enter IF/ID
    logic        bubble_req;   // missed fetch with IF/ID free -> bubble
    logic [31:0] pc_plus4;

    // Low redirect bits are dropped on purpose; only the word address matters.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^RedirectPC[1:0];

    assign pc_plus4 = pc + 32'd4;

    // FSM transitions, PC and buffer updates, and the IF/ID load decision
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        buf_data_nxt = buf_data;
        buf_vld_nxt  = buf_vld;
        advance      = 1'b0;
        load_req     = 1'b0;
        load_instr   = 32'h0;
        bubble_req   = 1'b0;

        if (Redirect) begin
            // Resolved control transfer: anything in flight or buffered is stale.
            pc_nxt       = {RedirectPC[31:2], 2'b00};
            buf_vld_nxt  = 1'b0;
            buf_data_nxt = 32'h0;
            state_nxt    = ST_FETCH;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    if (IMemAck) begin
                        if (!PCWrite && !IFIDWrite) begin
                            advance    = 1'b1;
                            load_req   = 1'b1;
                            load_instr = IMemData;
                        end else begin
                            // Memory answered during a stall: park the word.
                            buf_data_nxt = IMemData;
                            buf_vld_nxt  = 1'b1;
                            state_nxt    = ST_HOLD;
                        end
                    end else if (!IFIDWrite) begin
                        bubble_req = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!PCWrite && !IFIDWrite) begin
                        advance      = 1'b1;
                        load_req     = 1'b1;
                        load_instr   = buf_data;
                        buf_vld_nxt  = 1'b0;
                        buf_data_nxt = 32'h0;
                        state_nxt    = ST_FETCH;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        if (advance) begin
            pc_nxt = pc_plus4;
        end
    end

    // IF/ID next value: Redirect > Flush > IFIDWrite hold > load
    always_comb begin
        ifid_pc4_nxt   = IFID_PC4;
        ifid_instr_nxt = IFID_Instr;
        ifid_valid_nxt = IFID_Valid;
        if (Redirect || FlushSignal || bubble_req) begin
            ifid_pc4_nxt   = 32'h0;
            ifid_instr_nxt = 32'h0;
            ifid_valid_nxt = 1'b0;
        end else if (load_req) begin
            // load_req is only raised with IFIDWrite=0, so the hold wins otherwise.
            ifid_pc4_nxt   = pc_plus4;
            ifid_instr_nxt = load_instr;
            ifid_valid_nxt = 1'b1;
        end
    end

    // State, PC, buffer and IF/ID registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            pc         <= {RESET_PC[31:2], 2'b00};
            buf_data   <= 32'h0;
            buf_vld    <= 1'b0;
            req_q      <= 1'b0;
            IFID_PC4   <= 32'h0;
            IFID_Instr <= 32'h0;
            IFID_Valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            buf_data   <= buf_data_nxt;
            buf_vld    <= buf_vld_nxt;
            req_q      <= (state_nxt == ST_FETCH);
            IFID_PC4   <= ifid_pc4_nxt;
            IFID_Instr <= ifid_instr_nxt;
            IFID_Valid <= ifid_valid_nxt;
        end
    end

    assign IMemReq   = req_q;
    assign IMemAddr  = pc;
    assign FetchBusy = req_q & ~IMemAck;
    assign dbg_state = state;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Count active cycles without PC progress, saturating at all-ones
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt <= 16'h0;
        end else if ((state == ST_FETCH || state == ST_HOLD) && !advance &&
                     !Redirect && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign FetchStallCnt = stall_cnt;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 PCWrite  input  1  hazard-unit hold; 1 = keep PC (stall).
REQ-005 IFIDWrite  input  1  hazard-unit hold; 1 = keep IF/ID register contents.
REQ-006 FlushSignal  input  1  1 = load bubble into IF/ID.
REQ-007 Redirect  input  1  taken branch, j/jal or jr resolved in EX.
REQ-008 RedirectPC  input  32  target address, valid when Redirect=1.
REQ-009 IMemReq  output  1  instruction memory request.
REQ-010 IMemAddr  output  32  request address, word aligned.
REQ-011 IMemAck  input  1  memory accept; meaningful only while IMemReq=1.
REQ-012 IMemData  input  32  instruction, valid in the IMemAck cycle.
REQ-013 IFID_PC4  output  32  registered PC+4 of the instruction in IF/ID.
REQ-014 IFID_Instr  output  32  registered instruction.
REQ-015 IFID_Valid  output  1  1 = IF/ID holds a real instruction.
REQ-016 FetchBusy  output  1  1 = IMemReq high and IMemAck low this cycle.

Function
REQ-017 FSM states: IDLE, FETCH, HOLD; IDLE -> FETCH unconditionally after one cycle.
REQ-018 FETCH: IMemReq=1, IMemAddr=PC; in HOLD and IDLE IMemReq=0, IMemAddr=PC.
REQ-019 FETCH, IMemAck=1, PCWrite=0, IFIDWrite=0: IF/ID <= {PC+4, IMemData, 1}, PC <= PC+4, stay FETCH.
REQ-020 FETCH, IMemAck=1, PCWrite=1 or IFIDWrite=1: IMemData captured in a one-entry buffer, PC unchanged, go HOLD.
REQ-021 FETCH, IMemAck=0: PC unchanged, request repeated at the same address; if IFIDWrite=0, IF/ID <= bubble.
REQ-022 HOLD: when PCWrite=0 and IFIDWrite=0, IF/ID <= {PC+4, buffer, 1}, PC <= PC+4, go FETCH; otherwise stay HOLD.
REQ-023 Bubble: IFID_Instr=32'h0, IFID_PC4=32'h0, IFID_Valid=0.
REQ-024 Redirect=1, any state: PC <= RedirectPC, buffer discarded, same-cycle IMemData discarded, IF/ID <= bubble, go FETCH.
REQ-025 Priority: Reset > Redirect > FlushSignal > IFIDWrite hold > normal load.
REQ-026 FlushSignal=1 without Redirect: IF/ID <= bubble; PC/FSM follow REQ-019..022, except that any instruction REQ-019/022 would load is dropped instead, with PC still advanced.
REQ-027 IFIDWrite=1 without flush: IF/ID keeps its value.
REQ-028 PC+4 arithmetic modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-029 RedirectPC[1:0] ignored; PC[1:0] always 2'b00.
REQ-030 FetchBusy combinational from state and IMemAck; all other outputs registered.

Reset
REQ-031 Reset=1 at a rising edge: state IDLE, PC=RESET_PC, buffer empty, IF/ID bubble, IMemReq=0 the following cycle.
REQ-032 Reset mid-request or in HOLD abandons the transaction; no IF/ID write or PC advance occurs from it.
REQ-033 Reset overrides Redirect, FlushSignal and hold inputs in the same cycle.

Configuration
REQ-034 Macro FETCH_STALL_CNT_EN defined: output FetchStallCnt [15:0] counts cycles with state FETCH or HOLD and PC not advancing and no Redirect; saturates at 16'hFFFF; 0 on Reset.
REQ-035 Macro undefined: FetchStallCnt port and counter absent; all other behaviour identical.

Verification
REQ-036 Reset, IMemAck=1 every cycle, no holds -> IMemAddr 0,4,8; IFID_PC4 4,8,C with Valid=1 on consecutive cycles.
REQ-037 PC=0x10, IMemAck=1 with PCWrite=IFIDWrite=1 for 3 cycles -> HOLD, IMemReq=0, IF/ID unchanged; release -> IFID_PC4=0x14 from buffer, next IMemAddr=0x14.
REQ-038 FETCH at 0x20, IMemAck low 2 cycles -> FetchBusy=1, IMemAddr=0x20 held, IF/ID bubbles; ack -> IFID_PC4=0x24.
REQ-039 In HOLD, Redirect=1, RedirectPC=0x100 -> buffer dropped, IF/ID bubble, next IMemAddr=0x100, next load IFID_PC4=0x104.
REQ-040 PC=0xFFFF_FFFC, IMemAck=1 -> IFID_PC4=0x0, next IMemAddr=0x0.
REQ-041 Reset asserted during IMemAck cycle at PC=0x40 -> no IF/ID write, next IMemAddr=RESET_PC; with FETCH_STALL_CNT_EN, FetchStallCnt=0.
